// File: rtl/aes_round_key_sequencer.sv
// Iterative AES-128 key schedule. Streams the 11 round keys one per handshake,
// ascending (forward expansion) or descending (full forward pass, then reverse
// expansion). One shared S-box word serves both step directions.

// Single-byte forward AES S-box lookup.
module aes_sbox_lane (
  input  logic [7:0] a,
  output logic [7:0] s
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign s = SBOX[a];
endmodule

module aes_round_key_sequencer (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic [127:0] i_Key,
  input  logic         i_fEncrypt,
  input  logic         i_fStart,
  output logic         o_fBusy,
  output logic         o_fValid,
  input  logic         i_fReady,
  output logic [127:0] o_RoundKey,
  output logic [3:0]   o_Round,
  output logic         o_fDone
);
  localparam int NUM_LANES = 4;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;

  logic [1:0]   state;
  logic         enc;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  r1, r2, r3;
  logic         fwd;
  logic [31:0]  sub_src;
  logic [NUM_LANES-1:0][7:0] sub_in, sub_out;
  logic [3:0]   rcon_idx;
  logic [7:0]   rcon;
  logic [31:0]  t;
  logic [127:0] key_fwd, key_rev;

  assign {w0, w1, w2, w3} = o_RoundKey;

  // Reverse step derives w3..w1 first; the new w3 feeds the S-box.
  assign r3 = w3 ^ w2;
  assign r2 = w2 ^ w1;
  assign r1 = w1 ^ w0;

  // Expansion always runs forward; in EMIT the latched mode picks direction.
  assign fwd      = (state == ST_EXPAND) || enc;
  assign sub_src  = fwd ? w3 : r3;
  assign sub_in   = {sub_src[23:0], sub_src[31:24]};
  // Forward r->r+1 uses Rcon[r+1]; reverse r+1->r also uses Rcon[r+1] = Rcon[round].
  assign rcon_idx = fwd ? o_Round + 4'd1 : o_Round;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_sbox
      aes_sbox_lane u_lane (.a(sub_in[gi]), .s(sub_out[gi]));
    end
  endgenerate

  // Round constant table indexed 1..10.
  always_comb begin
    rcon = 8'h00;
    case (rcon_idx)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t = sub_out ^ {rcon, 24'h0};

  // Forward and reverse next-key words.
  always_comb begin
    logic [31:0] n0, n1, n2;
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    key_fwd = {n0, n1, n2, w3 ^ n2};
    key_rev = {w0 ^ t, r1, r2, r3};
  end

  // Sequencer FSM: idle/start, forward pre-expansion, handshake-driven emission.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state      <= ST_IDLE;
      enc        <= 1'b1;
      o_fBusy    <= 1'b0;
      o_fValid   <= 1'b0;
      o_fDone    <= 1'b0;
      o_RoundKey <= '0;
      o_Round    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_fDone <= 1'b0;
          if (i_fStart) begin
            o_RoundKey <= i_Key;
            o_Round    <= 4'd0;
            enc        <= i_fEncrypt;
            o_fBusy    <= 1'b1;
            o_fValid   <= i_fEncrypt;
            state      <= i_fEncrypt ? ST_EMIT : ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          o_RoundKey <= key_fwd;
          o_Round    <= o_Round + 4'd1;
          if (o_Round == 4'd9) begin
            state    <= ST_EMIT;
            o_fValid <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (i_fReady) begin
            if (o_Round == (enc ? 4'd10 : 4'd0)) begin
              state    <= ST_IDLE;
              o_fValid <= 1'b0;
              o_fBusy  <= 1'b0;
              o_fDone  <= 1'b1;
            end else if (enc) begin
              o_RoundKey <= key_fwd;
              o_Round    <= o_Round + 4'd1;
            end else begin
              o_RoundKey <= key_rev;
              o_Round    <= o_Round - 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
